// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared types and sizing helpers for the nibble-serial add/sub sequencer
package add_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NIB_W = 4;

  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/adder_1b.sv
// rtl/adder_1b.sv - 4-bit ripple-carry adder used as the shared nibble datapath
module adder_1b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - WIDTH-bit add/sub done one nibble per cycle through a single 4-bit adder
// Optional signed-overflow flag enabled by macro ADD_SEQ_OVF_EN.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, result_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q, cout_q;
  logic [NIB_W-1:0] nib_a, nib_b, nib_sum;
  logic             nib_cout;
  logic             accept, last_step;

  assign accept    = (state_q == IDLE) && in_valid;
  assign last_step = (state_q == RUN) && (idx_q == LAST_IDX);

  // Constant-index mux keeps the slice select simple for synthesis.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = opa_q[NIB_W*i +: NIB_W];
        nib_b = opb_q[NIB_W*i +: NIB_W];
      end
    end
  end

  adder_1b u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (idx_q == LAST_IDX) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtract is a + ~b + 1: invert B once at accept and seed the carry with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      opa_q    <= a;
      opb_q    <= sub ? ~b : b;
      carry_q  <= sub ? 1'b1 : cin;
      idx_q    <= '0;
      result_q <= '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NIB; i++) begin
        if (idx_q == IDX_W'(i)) result_q[NIB_W*i +: NIB_W] <= nib_sum;
      end
      carry_q <= nib_cout;
      idx_q   <= idx_q + 1'b1;
      if (last_step) cout_q <= nib_cout;
    end
  end

  assign sum  = result_q;
  assign cout = cout_q;

`ifdef ADD_SEQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ovf_q <= 1'b0;
    else if (last_step) ovf_q <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                                 (nib_sum[NIB_W-1] != opa_q[WIDTH-1]);
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - self-checking bench for add_seq_ctrl against an arithmetic reference model
module tb_add_seq_ctrl;

  localparam int W   = 16;
  localparam int NIB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          cout;
  logic          overflow;
  logic          busy;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
  );

  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mcin, input logic msub,
                                output logic [W-1:0] esum, output logic ecout, output logic eovf);
    int unsigned ua, ub, ur;
    int sa, sb, r;
    ua = ma; ub = mb;
    sa = $signed(ma); sb = $signed(mb);
    if (msub) begin
      ur = ua - ub; ecout = (ua >= ub); r = sa - sb;
    end else begin
      ur = ua + ub + mcin; ecout = (ur > 65535); r = sa + sb + mcin;
    end
    esum = ur[W-1:0];
    eovf = (r > 32767) || (r < -32768);
`ifndef ADD_SEQ_OVF_EN
    eovf = 1'b0;
`endif
  endfunction

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic icin, input logic isub, output int acc_cyc);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    #1 in_valid = 1'b0;
  endtask

  // Scrambles operand inputs while busy; they must be ignored.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom);
    end while (!out_valid && lat < 20);
  endtask

  task automatic take_result();
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors += 6;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (sum !== '0)         begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF};
    logic [W-1:0] tb [5] = '{16'h0F0F, 16'h0001, 16'h0007, 16'h0005, 16'h0001};
    logic         ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] es [5] = '{16'h2143, 16'h0000, 16'hFFFE, 16'h0002, 16'h8000};
    logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         eo [5];
    int acc, lat;
    eo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ADD_SEQ_OVF_EN
    eo[4] = 1'b1;
`endif
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i], 1'b0, ts[i], acc);
      wait_valid(lat);
      vectors += 6;
      if (lat != NIB)         begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, NIB); end
      if (sum !== es[i])      begin errors++; $display("FAIL dir%0d_sum: got %h expected %h", i, sum, es[i]); end
      if (cout !== ec[i])     begin errors++; $display("FAIL dir%0d_cout: got %b expected %b", i, cout, ec[i]); end
      if (overflow !== eo[i]) begin errors++; $display("FAIL dir%0d_overflow: got %b expected %b", i, overflow, eo[i]); end
      if (busy !== 1'b1)      begin errors++; $display("FAIL dir%0d_busy: got %b expected 1", i, busy); end
      if (in_ready !== 1'b0)  begin errors++; $display("FAIL dir%0d_in_ready: got %b expected 0", i, in_ready); end
      take_result();
      vectors += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_drop: got %b expected 0", i, out_valid); end
      if (in_ready !== 1'b1)  begin errors++; $display("FAIL dir%0d_ready: got %b expected 1", i, in_ready); end
      if (sum !== es[i])      begin errors++; $display("FAIL dir%0d_retain: got %h expected %h", i, sum, es[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ra, rb, esum;
    logic rc, rs, ecout, eovf;
    int acc, lat;
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
    model(ra, rb, rc, rs, esum, ecout, eovf);
    issue(ra, rb, rc, rs, acc);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      vectors += 5;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_out_valid: got %b expected 1", k, out_valid); end
      if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp%0d_in_ready: got %b expected 0", k, in_ready); end
      if (sum !== esum)       begin errors++; $display("FAIL bp%0d_sum: got %h expected %h", k, sum, esum); end
      if (cout !== ecout)     begin errors++; $display("FAIL bp%0d_cout: got %b expected %b", k, cout, ecout); end
      if (overflow !== eovf)  begin errors++; $display("FAIL bp%0d_overflow: got %b expected %b", k, overflow, eovf); end
    end
    take_result();
    vectors += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_midrun_reset();
    int acc, lat, seen;
    issue(16'hABCD, 16'h1111, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    vectors += 5;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    if (sum !== '0)         begin errors++; $display("FAIL rst_sum: got %h expected 0000", sum); end
    if (cout !== 1'b0)      begin errors++; $display("FAIL rst_cout: got %b expected 0", cout); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < NIB + 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin errors++; $display("FAIL rst_no_pulse: got %0d valid cycles expected 0", seen); end
    issue(16'h1234, 16'h0F0F, 1'b0, 1'b0, acc);
    wait_valid(lat);
    vectors += 2;
    if (sum !== 16'h2143) begin errors++; $display("FAIL rst_after_sum: got %h expected 2143", sum); end
    if (lat != NIB)       begin errors++; $display("FAIL rst_after_latency: got %0d expected %0d", lat, NIB); end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] esum;
    logic ecout, eovf;
    int acc1, acc2, lat;
    issue(16'h00FF, 16'h0101, 1'b1, 1'b0, acc1);
    wait_valid(lat);
    take_result();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, acc2);
    wait_valid(lat);
    model(16'h8000, 16'h0001, 1'b0, 1'b1, esum, ecout, eovf);
    vectors += 4;
    if (acc2 - acc1 != NIB + 2) begin errors++; $display("FAIL b2b_interval: got %0d expected %0d", acc2 - acc1, NIB + 2); end
    if (sum !== esum)      begin errors++; $display("FAIL b2b_sum: got %h expected %h", sum, esum); end
    if (cout !== ecout)    begin errors++; $display("FAIL b2b_cout: got %b expected %b", cout, ecout); end
    if (overflow !== eovf) begin errors++; $display("FAIL b2b_overflow: got %b expected %b", overflow, eovf); end
    take_result();
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, esum;
    logic rc, rs, ecout, eovf;
    int acc, lat;
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      model(ra, rb, rc, rs, esum, ecout, eovf);
      issue(ra, rb, rc, rs, acc);
      wait_valid(lat);
      vectors += 4;
      if (lat != NIB)        begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, NIB); end
      if (sum !== esum)      begin errors++; $display("FAIL rnd%0d_sum: a=%h b=%h cin=%b sub=%b got %h expected %h", n, ra, rb, rc, rs, sum, esum); end
      if (cout !== ecout)    begin errors++; $display("FAIL rnd%0d_cout: got %b expected %b", n, cout, ecout); end
      if (overflow !== eovf) begin errors++; $display("FAIL rnd%0d_overflow: got %b expected %b", n, overflow, eovf); end
      take_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_midrun_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
